// File: rtl/cmp_signed_exerciser.sv
// cmp_signed_exerciser: exhaustive sweep of a signed comparator, counting mismatches and latching the first failing pair
module cmp_signed_exerciser #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic               gt_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] vec_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] vec_q, vec_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   err_q, err_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic               exp_gt, miss;
  assign a_o       = vec_q[2*WIDTH-1:WIDTH];
  assign b_o       = vec_q[WIDTH-1:0];
  assign exp_gt    = $signed(a_o) > $signed(b_o);
  assign miss      = gt_i != exp_gt;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = DRIVE;
        vec_d    = '0;
        cnt_d    = '0;
        err_d    = '0;
        fail_a_d = '0;
        fail_b_d = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        pass_d   = 1'b0;
      end
      DRIVE: begin
        state_d = cnt_q == CW'(SETTLE - 1) ? CHECK : DRIVE;
        cnt_d   = cnt_q == CW'(SETTLE - 1) ? '0 : cnt_q + CW'(1);
      end
      CHECK: begin
        // first mismatch is recognised by the counter still being zero; saturation never wraps it back
        if (miss) begin
          err_d    = &err_q ? err_q : err_q + (2*WIDTH+1)'(1);
          fail_a_d = err_q == '0 ? a_o : fail_a_q;
          fail_b_d = err_q == '0 ? b_o : fail_b_q;
        end
        if (&vec_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = err_d == '0;
        end else begin
          state_d = DRIVE;
          vec_d   = vec_q + (2*WIDTH)'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end
endmodule
